// File: rtl/tag_stream_distributor.sv
// Fans one tag stream out to NUM_BRANCHES channel-filtered FWFT FIFOs, each blocking or lossy.
// Define TAG_DIST_DROP_COUNT_EN to build the per-branch saturating drop counters.
module tag_stream_distributor #(
   parameter int WORD_WIDTH    = 4,
   parameter int TIME_WIDTH    = 64,
   parameter int CHANNEL_WIDTH = 6,
   parameter int NUM_BRANCHES  = 3,
   parameter int FIFO_DEPTH    = 8,
   parameter int FORWARD_EMPTY = 1
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               s_tvalid,
   output logic                                               s_tready,
   input  logic [WORD_WIDTH-1:0]                              s_tkeep,
   input  logic [WORD_WIDTH*TIME_WIDTH-1:0]                   s_tagtime,
   input  logic [WORD_WIDTH*CHANNEL_WIDTH-1:0]                s_channel,
   input  logic [TIME_WIDTH-1:0]                              s_lowest_time_bound,
   input  logic [NUM_BRANCHES*(2**CHANNEL_WIDTH)-1:0]         cfg_channel_mask,
   input  logic [NUM_BRANCHES-1:0]                            cfg_lossy,
   output logic [NUM_BRANCHES-1:0]                            m_tvalid,
   input  logic [NUM_BRANCHES-1:0]                            m_tready,
   output logic [NUM_BRANCHES*WORD_WIDTH-1:0]                 m_tkeep,
   output logic [NUM_BRANCHES*WORD_WIDTH*TIME_WIDTH-1:0]      m_tagtime,
   output logic [NUM_BRANCHES*WORD_WIDTH*CHANNEL_WIDTH-1:0]   m_channel,
   output logic [NUM_BRANCHES*TIME_WIDTH-1:0]                 m_lowest_time_bound,
   output logic [NUM_BRANCHES*32-1:0]                         drop_count,
   input  logic                                               drop_clear
);
   localparam int NUM_CHANNELS = 2 ** CHANNEL_WIDTH;
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam int CNT_W        = PTR_W + 1;
   localparam int TT_W         = WORD_WIDTH * TIME_WIDTH;
   localparam int CH_W         = WORD_WIDTH * CHANNEL_WIDTH;
   localparam int ENTRY_W      = WORD_WIDTH + TT_W + CH_W + TIME_WIDTH;

   logic [NUM_BRANCHES-1:0] branch_full;
   logic                    s_accept;

   // Readiness depends only on registered full flags, never on s_tvalid.
   assign s_tready = ~rst & (&(cfg_lossy | ~branch_full));
   assign s_accept = s_tvalid & s_tready;

   for (genvar gi = 0; gi < NUM_BRANCHES; gi++) begin : g_branch
      logic [NUM_CHANNELS-1:0] mask;
      logic [WORD_WIDTH-1:0]   fkeep;
      logic                    want;
      logic                    push;
      logic                    pop;
      logic                    drop;
      logic                    valid;
      logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]        count_q, count_d;
      logic                    full_q, full_d;
      logic [ENTRY_W-1:0]      mem_q [FIFO_DEPTH];
      logic [ENTRY_W-1:0]      head;

      assign mask = cfg_channel_mask[gi*NUM_CHANNELS +: NUM_CHANNELS];

      always_comb begin
         fkeep = '0;
         for (int i = 0; i < WORD_WIDTH; i++) begin
            fkeep[i] = s_tkeep[i] & mask[s_channel[i*CHANNEL_WIDTH +: CHANNEL_WIDTH]];
         end
      end

      // A full branch never takes a push, even when it pops in the same cycle.
      assign want  = s_accept & ((|fkeep) | (FORWARD_EMPTY != 0));
      assign push  = want & ~full_q;
      assign drop  = want & full_q;
      assign valid = (count_q != '0);
      assign pop   = valid & m_tready[gi];

      always_comb begin
         wr_ptr_d = wr_ptr_q;
         rd_ptr_d = rd_ptr_q;
         count_d  = count_q;
         if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
         full_d = (count_d == CNT_W'(FIFO_DEPTH));
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
         end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
         end
      end

      always_ff @(posedge clk) begin
         if (push) begin
            mem_q[wr_ptr_q] <= {fkeep, s_tagtime, s_channel, s_lowest_time_bound};
         end
      end

      // Head is forced to zero while empty so idle outputs read as 0.
      assign head            = valid ? mem_q[rd_ptr_q] : '0;
      assign branch_full[gi] = full_q;
      assign m_tvalid[gi]    = valid;
      assign m_tkeep[gi*WORD_WIDTH +: WORD_WIDTH]          = head[ENTRY_W-1 -: WORD_WIDTH];
      assign m_tagtime[gi*TT_W +: TT_W]                    = head[TIME_WIDTH + CH_W +: TT_W];
      assign m_channel[gi*CH_W +: CH_W]                    = head[TIME_WIDTH +: CH_W];
      assign m_lowest_time_bound[gi*TIME_WIDTH +: TIME_WIDTH] = head[0 +: TIME_WIDTH];

`ifdef TAG_DIST_DROP_COUNT_EN
      logic [31:0] drop_cnt_q, drop_cnt_d;

      always_comb begin
         drop_cnt_d = drop_cnt_q;
         if (drop_clear) begin
            drop_cnt_d = '0;
         end else if (drop && (drop_cnt_q != 32'hFFFF_FFFF)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            drop_cnt_q <= '0;
         end else begin
            drop_cnt_q <= drop_cnt_d;
         end
      end

      assign drop_count[gi*32 +: 32] = drop_cnt_q;
`else
      logic unused_drop;
      assign unused_drop             = drop;
      assign drop_count[gi*32 +: 32] = 32'd0;
`endif
   end

`ifndef TAG_DIST_DROP_COUNT_EN
   logic unused_drop_clear;
   assign unused_drop_clear = drop_clear;
`endif
endmodule

// File: doc/tag_stream_distributor.md
# tag_stream_distributor

- Parametrised fan-out stage that replaces the fixed three-way broadcast in the measurement layer.
- Takes one tag stream (WORD_WIDTH tags per beat) and delivers it to NUM_BRANCHES measurement branches.
- Each branch gets its own per-channel filter, its own FIFO and a blocking or lossy overflow mode, so one slow consumer need not stall the others.
- Sits between the tag input interface and the user measurement modules (histogram, counter, user designs).

## Interface

**Parameters**

- WORD_WIDTH, 4: tags per beat.
- TIME_WIDTH, 64: tag time width.
- CHANNEL_WIDTH, 6: channel field width; NUM_CHANNELS = 2**CHANNEL_WIDTH.
- NUM_BRANCHES, 3: output branches, 1..16.
- FIFO_DEPTH, 8: beats per branch FIFO; power of two, ≥2.
- FORWARD_EMPTY, 1: forward beats whose filtered keep is all-zero, so lowest_time_bound keeps advancing.

**Ports** (clock and reset first)

- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- s_tvalid, in, 1: input beat valid.
- s_tready, out, 1: input beat accepted when s_tvalid & s_tready.
- s_tkeep, in, WORD_WIDTH: per-tag valid.
- s_tagtime, in, WORD_WIDTH*TIME_WIDTH: packed tag times; tag i at [i*TIME_WIDTH +: TIME_WIDTH].
- s_channel, in, WORD_WIDTH*CHANNEL_WIDTH: packed channels.
- s_lowest_time_bound, in, TIME_WIDTH: beat time bound.
- cfg_channel_mask, in, NUM_BRANCHES*NUM_CHANNELS: bit [b*NUM_CHANNELS+c] passes channel c to branch b.
- cfg_lossy, in, NUM_BRANCHES: 1 means the branch drops beats when full; 0 means it back-pressures.
- m_tvalid, out, NUM_BRANCHES: per-branch valid.
- m_tready, in, NUM_BRANCHES: per-branch ready.
- m_tkeep, out, NUM_BRANCHES*WORD_WIDTH: filtered keep.
- m_tagtime, out, NUM_BRANCHES*WORD_WIDTH*TIME_WIDTH: per-branch tag times.
- m_channel, out, NUM_BRANCHES*WORD_WIDTH*CHANNEL_WIDTH: per-branch channels.
- m_lowest_time_bound, out, NUM_BRANCHES*TIME_WIDTH: per-branch time bound.
- drop_count, out, NUM_BRANCHES*32: beats dropped per branch.
- drop_clear, in, 1: synchronous clear of all drop counters.

## Operation

- **Readiness:** s_tready = !rst & AND over b of (cfg_lossy[b] | !full[b]). It is combinational from registered full flags only; no path from s_tvalid.
- **Filtering:** on an accepted beat, branch b computes fkeep[i] = s_tkeep[i] & cfg_channel_mask[b*NUM_CHANNELS + channel_i].
- **Push decision for branch b:**
  - Push if (fkeep != 0 or FORWARD_EMPTY) and !full[b].
  - If the branch would push but is full (lossy only), drop the beat and increment drop_count[b]. Counter saturates at 0xFFFFFFFF.
  - FORWARD_EMPTY=0 with fkeep==0: no push, no drop.
- **Stored beat:** {fkeep, tagtime, channel, lowest_time_bound}. Tagtime and channel are stored unmodified; filtering acts only through keep.
- **Config sampling:** cfg_* are sampled on each accepted beat, so a change applies from the next accepted beat. Beats already queued are unaffected.
- **Branch FIFO:** first-word-fall-through.
  - Pop on m_tvalid[b] & m_tready[b].
  - Occupancy counter is $clog2(FIFO_DEPTH)+1 bits; read and write pointers wrap modulo FIFO_DEPTH.
- **Ordering:** per-branch beat order equals input order. No ordering relation exists between branches.
- **Full branch:** full means occupancy == FIFO_DEPTH. A full branch does not accept a push even if it pops in the same cycle; there is no bypass.
- **Drop counter clear:** drop_clear and a drop in the same cycle give 0; clear wins.

## Timing

- **Reset values:** all FIFOs empty; m_tvalid=0; m_tkeep=0; m_tagtime, m_channel and m_lowest_time_bound = 0; drop_count=0; s_tready=0 while rst=1.
- **After reset:** s_tready=1 in the first cycle after rst falls, provided all FIFOs are empty.
- **Latency:** a beat accepted in cycle N into an empty FIFO shows m_tvalid[b]=1 in cycle N+1.
- **Throughput:** one beat per cycle per branch when m_tready is held high.
- **Full flag:**
  - Updates in the cycle after a push or pop.
  - A pop in cycle N re-enables s_tready in cycle N+1 for a blocking branch.
- **Output stability:** m_* data is stable while m_tvalid=1 and m_tready=0.
- **Reset mid-operation:** rst=1 empties all FIFOs in the same cycle. Queued beats are discarded and are not counted as drops. m_tvalid goes low in cycle N+1.

## Configuration

- **TAG_DIST_DROP_COUNT_EN defined:** per-branch 32-bit saturating drop counters are built as described above.
- **TAG_DIST_DROP_COUNT_EN undefined:**
  - Counter logic is not built.
  - drop_count is tied to 0 and drop_clear is ignored.
  - Lossy dropping itself is unchanged.

## Test plan

- **Broadcast:** NUM_BRANCHES=3, all masks all-ones, all m_tready=1. Send 100 beats, tkeep=4'b1111 → each branch outputs the same 100 beats in order, 1 cycle latency, s_tready never low.
- **Filtering:** mask for branch 1 = channel 5 only. Beat with channels {5,2,5,9} and tkeep=4'b1111 → branch 1 sees tkeep=4'b0101.
  - FORWARD_EMPTY=0, beat with no channel 5 → branch 1 gets no beat, branch 0 gets it.
- **Blocking back-pressure:** FIFO_DEPTH=8, cfg_lossy=0, m_tready[2]=0. Send 20 beats → s_tready falls after 8 accepted beats. Raise m_tready[2] → the remaining 12 beats arrive, none lost, drop_count all 0.
- **Lossy drop:** cfg_lossy[2]=1, m_tready[2]=0. Send 20 beats → branches 0/1 receive 20, branch 2 holds the first 8, drop_count[2]=12 with the macro defined (0 without).
  - drop_clear together with a drop → drop_count[2]=0.
- **Reset mid-stream:** FIFOs half full, assert rst for one cycle → m_tvalid=0 next cycle, s_tready=0 during rst and 1 after. Subsequent beats arrive with 1 cycle latency, and no pre-reset beat reappears.
- **Wrap-around:** FIFO_DEPTH=2, random m_tready at 50% over 1000 beats → scoreboard matches per branch. Pointers wrap without loss or duplication.
